shift_ctrl: RTL and testbench



---
 rtl/shift_ctrl_pkg.sv | 28 ++
 rtl/Shifter.sv | 12 +
 rtl/shift_ctrl.sv | 165 ++++++++++++++++
 tb/tb_shift_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the shifter sequencing controller.
package shift_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PASS2 = 1'b1
    } state_e;

    function automatic logic [DATA_W-1:0] rev32(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/Shifter.sv
// Shared 32-bit zero-fill left barrel shifter.
module Shifter
    import shift_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [DATA_W-1:0]  o_data
);

    assign o_data = i_data << i_shamt;

endmodule

// File: rtl/shift_ctrl.sv
// Arbitrates two requesters onto the left-only shifter, derives right shifts and
// two-pass rotates around it, and holds the result in a one-entry response slot.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter logic RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [OP_W-1:0]    req0_op,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [OP_W-1:0]    req1_op,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_id
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_rr;
    logic [DATA_W-1:0]   r_hold;
    logic [DATA_W-1:0]   r_p2_data;
    logic [SHAMT_W-1:0]  r_p2_shamt;
    logic                r_p2_id;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_id;

    logic                w_slot_free;
    logic                w_can;
    logic                w_prefer1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_acc;
    logic                w_sel;
    logic [OP_W-1:0]     w_op;
    logic [DATA_W-1:0]   w_data;
    logic [SHAMT_W-1:0]  w_shamt;
    logic                w_rol2;
    logic [DATA_W-1:0]   w_sh_in;
    logic [SHAMT_W-1:0]  w_sh_amt;
    logic [DATA_W-1:0]   w_sh_out;
    logic [DATA_W-1:0]   w_result;

    // Grant never looks at the same port's valid, so each ready is valid-independent.
    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign w_can       = (r_state == ST_IDLE) && w_slot_free && !rst;
    assign w_prefer1   = RR_EN && r_rr;
    assign w_gnt0      = w_can && !(req1_valid && w_prefer1);
    assign w_gnt1      = w_can && !(req0_valid && !w_prefer1);
    assign w_acc0      = req0_valid && w_gnt0;
    assign w_acc1      = req1_valid && w_gnt1;
    assign w_acc       = w_acc0 || w_acc1;
    assign w_sel       = w_acc1;

    assign w_op    = w_sel ? req1_op    : req0_op;
    assign w_data  = w_sel ? req1_data  : req0_data;
    assign w_shamt = w_sel ? req1_shamt : req0_shamt;
    assign w_rol2  = w_acc && (w_op == OP_ROL) && (w_shamt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_rol2) w_state_nxt = ST_PASS2;
            ST_PASS2: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Pre/post processing: right shifts via reversal, SRA of negatives via inversion,
    // rotate pass 2 shifts the saved operand right by 32-n and merges the held left part.
    always_comb begin
        w_sh_in  = w_data;
        w_sh_amt = w_shamt;
        w_result = w_sh_out;
        if (r_state == ST_PASS2) begin
            w_sh_in  = rev32(r_p2_data);
            w_sh_amt = SHAMT_W'(6'd32 - {1'b0, r_p2_shamt});
            w_result = rev32(w_sh_out) | r_hold;
        end else begin
            case (w_op)
                OP_SRL: begin
                    w_sh_in  = rev32(w_data);
                    w_result = rev32(w_sh_out);
                end
                OP_SRA: begin
                    if (w_data[DATA_W-1]) begin
                        w_sh_in  = rev32(~w_data);
                        w_result = ~rev32(w_sh_out);
                    end else begin
                        w_sh_in  = rev32(w_data);
                        w_result = rev32(w_sh_out);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    Shifter u_shifter (
        .i_data  (w_sh_in),
        .i_shamt (w_sh_amt),
        .o_data  (w_sh_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
            r_hold      <= '0;
            r_p2_data   <= '0;
            r_p2_shamt  <= '0;
            r_p2_id     <= 1'b0;
            r_rr        <= 1'b0;
        end else begin
            if (r_state == ST_PASS2) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_result;
                r_rsp_id    <= r_p2_id;
            end else if (w_acc && !w_rol2) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_result;
                r_rsp_id    <= w_sel;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_rol2) begin
                r_hold     <= w_result;
                r_p2_data  <= w_data;
                r_p2_shamt <= w_shamt;
                r_p2_id    <= w_sel;
            end
            if (w_acc) begin
                r_rr <= !w_sel;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: a round-robin and a fixed-priority instance share stimulus,
// each checked every cycle against a transaction-level model plus directed literals.
module tb_shift_ctrl;

    logic        clk;
    logic        rst;
    logic        v0, v1;
    logic [1:0]  op0, op1;
    logic [31:0] d0, d1;
    logic [4:0]  n0, n1;
    logic        rsp_ready;

    logic        rv [2];
    logic [31:0] rd [2];
    logic        ri [2];
    logic        r0 [2];
    logic        r1 [2];

    int n_chk;
    int n_fail;
    bit chk_en;

    shift_ctrl #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0[0]), .req0_op(op0), .req0_data(d0), .req0_shamt(n0),
        .req1_valid(v1), .req1_ready(r1[0]), .req1_op(op1), .req1_data(d1), .req1_shamt(n1),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_data(rd[0]), .rsp_id(ri[0])
    );

    shift_ctrl #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0[1]), .req0_op(op0), .req0_data(d0), .req0_shamt(n0),
        .req1_valid(v1), .req1_ready(r1[1]), .req1_op(op1), .req1_data(d1), .req1_shamt(n1),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_data(rd[1]), .rsp_id(ri[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of one operation, straight from the arithmetic meaning of each op.
    function automatic bit [31:0] ref_op(input bit [1:0] op, input bit [31:0] x, input bit [4:0] n);
        case (op)
            2'd0:    return x << n;
            2'd1:    return x >> n;
            2'd2:    return 32'($signed(x) >>> n);
            default: return (n == 5'd0) ? x : ((x << n) | (x >> (32 - int'(n))));
        endcase
    endfunction

    typedef struct {
        bit        valid;
        bit [31:0] data;
        bit        id;
        bit        busy;
        bit [31:0] pend;
        bit        pid;
        bit        rr;
    } mdl_t;

    mdl_t m [2];

    // Instance 0 is round-robin, instance 1 fixed priority.
    function automatic bit exp_ready(input int i, input int port);
        bit can;
        bit pref1;
        can   = !m[i].busy && (!m[i].valid || rsp_ready) && !rst;
        pref1 = (i == 0) && m[i].rr;
        if (port == 0) return can && !(v1 && pref1);
        return can && !(v0 && !pref1);
    endfunction

    always @(negedge clk) begin
        bit e0, e1, drained;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d rsp_valid", i), 32'(rv[i]), 32'(m[i].valid));
                if (m[i].valid) begin
                    chk($sformatf("dut%0d rsp_data", i), rd[i], m[i].data);
                    chk($sformatf("dut%0d rsp_id", i), 32'(ri[i]), 32'(m[i].id));
                end
                chk($sformatf("dut%0d req0_ready", i), 32'(r0[i]), 32'(exp_ready(i, 0)));
                chk($sformatf("dut%0d req1_ready", i), 32'(r1[i]), 32'(exp_ready(i, 1)));
            end
        end
        for (int i = 0; i < 2; i++) begin
            e0 = exp_ready(i, 0) && v0;
            e1 = exp_ready(i, 1) && v1;
            drained = m[i].valid && rsp_ready;
            if (rst) begin
                m[i] = '{default: 0};
            end else if (m[i].busy) begin
                m[i].valid = 1'b1;
                m[i].data  = m[i].pend;
                m[i].id    = m[i].pid;
                m[i].busy  = 1'b0;
            end else if (e0 || e1) begin
                bit [1:0]  op;
                bit [31:0] x;
                bit [4:0]  n;
                op = e1 ? op1 : op0;
                x  = e1 ? d1 : d0;
                n  = e1 ? n1 : n0;
                if (op == 2'd3 && n != 5'd0) begin
                    m[i].busy  = 1'b1;
                    m[i].pend  = ref_op(op, x, n);
                    m[i].pid   = e1;
                    m[i].valid = 1'b0;
                end else begin
                    m[i].valid = 1'b1;
                    m[i].data  = ref_op(op, x, n);
                    m[i].id    = e1;
                end
                m[i].rr = !e1;
            end else if (drained) begin
                m[i].valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int port, input bit [1:0] op, input bit [31:0] x, input bit [4:0] n);
        if (port == 0) begin
            v0 = 1'b1; op0 = op; d0 = x; n0 = n;
        end else begin
            v1 = 1'b1; op1 = op; d1 = x; n1 = n;
        end
    endtask

    task automatic single(input string name, input int port, input bit [1:0] op,
                          input bit [31:0] x, input bit [4:0] n, input bit [31:0] exp);
        v0 = 1'b0;
        v1 = 1'b0;
        set_req(port, op, x, n);
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s valid dut%0d", name, i), 32'(rv[i]), 32'd1);
            chk($sformatf("%s data dut%0d", name, i), rd[i], exp);
            chk($sformatf("%s id dut%0d", name, i), 32'(ri[i]), 32'(port));
        end
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        op0 = '0; op1 = '0; d0 = '0; d1 = '0; n0 = '0; n1 = '0;
        rsp_ready = 1'b1;

        chk("model sll", ref_op(2'd0, 32'h0000_0001, 5'd4), 32'h0000_0010);
        chk("model sra neg", ref_op(2'd2, 32'h8000_0000, 5'd31), 32'hFFFF_FFFF);
        chk("model sra pos", ref_op(2'd2, 32'h7FFF_FFF0, 5'd4), 32'h07FF_FFFF);
        chk("model rol", ref_op(2'd3, 32'h8000_0001, 5'd1), 32'h0000_0003);

        cyc();
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset valid dut%0d", i), 32'(rv[i]), 32'd0);
            chk($sformatf("reset data dut%0d", i), rd[i], 32'd0);
            chk($sformatf("reset id dut%0d", i), 32'(ri[i]), 32'd0);
            chk($sformatf("reset ready0 dut%0d", i), 32'(r0[i]), 32'd0);
            chk($sformatf("reset ready1 dut%0d", i), 32'(r1[i]), 32'd0);
        end
        chk_en = 1'b1;
        rst = 1'b0;

        single("sll", 0, 2'd0, 32'h0000_0001, 5'd4, 32'h0000_0010);
        single("sra neg", 1, 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        single("srl", 1, 2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001);
        single("sra pos", 1, 2'd2, 32'h7FFF_FFF0, 5'd4, 32'h07FF_FFFF);

        // Rotate by one: nothing accepted while the second pass runs.
        set_req(0, 2'd3, 32'h8000_0001, 5'd1);
        cyc();
        v0 = 1'b0;
        set_req(1, 2'd0, 32'h1, 5'd1);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rol pass2 ready0 dut%0d", i), 32'(r0[i]), 32'd0);
            chk($sformatf("rol pass2 ready1 dut%0d", i), 32'(r1[i]), 32'd0);
            chk($sformatf("rol pass2 valid dut%0d", i), 32'(rv[i]), 32'd0);
        end
        v1 = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rol data dut%0d", i), rd[i], 32'h0000_0003);
            chk($sformatf("rol valid dut%0d", i), 32'(rv[i]), 32'd1);
        end
        single("rol n0", 0, 2'd3, 32'h8000_0001, 5'd0, 32'h8000_0001);
        single("sll bp", 0, 2'd0, 32'h0000_0005, 5'd1, 32'h0000_000A);

        // Backpressure: slot held, requester waits, granted as rsp_ready rises.
        rsp_ready = 1'b0;
        set_req(1, 2'd0, 32'h0000_0003, 5'd2);
        repeat (3) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("bp data dut%0d", i), rd[i], 32'h0000_000A);
                chk($sformatf("bp ready0 dut%0d", i), 32'(r0[i]), 32'd0);
                chk($sformatf("bp ready1 dut%0d", i), 32'(r1[i]), 32'd0);
            end
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("bp regrant dut%0d", i), 32'(r1[i]), 32'd1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bp served data dut%0d", i), rd[i], 32'h0000_000C);
            chk($sformatf("bp served id dut%0d", i), 32'(ri[i]), 32'd1);
        end
        v1 = 1'b0;

        // Both requesting continuously.
        set_req(0, 2'd0, 32'h0000_0100, 5'd0);
        set_req(1, 2'd0, 32'h0000_0200, 5'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("rr id %0d", k), 32'(ri[0]), 32'(k % 2));
            chk($sformatf("fp id %0d", k), 32'(ri[1]), 32'd0);
            chk($sformatf("fp data %0d", k), rd[1], 32'h0000_0100);
        end
        v0 = 1'b0;
        v1 = 1'b0;

        // Reset in the middle of a rotate.
        set_req(0, 2'd3, 32'h1234_5678, 5'd3);
        cyc();
        v0 = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) chk($sformatf("rst pass2 valid dut%0d", i), 32'(rv[i]), 32'd0);
        set_req(0, 2'd0, 32'h0000_0100, 5'd0);
        set_req(1, 2'd0, 32'h0000_0200, 5'd0);
        #1;
        chk("rst rr ready0", 32'(r0[0]), 32'd1);
        chk("rst rr ready1", 32'(r1[0]), 32'd0);
        cyc();
        chk("rst after sll data", rd[0], 32'h0000_0100);
        chk("rst after sll id", 32'(ri[0]), 32'd0);
        v0 = 1'b0;
        v1 = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(63) == 0);
            rsp_ready = ($urandom_range(3) != 0);
            v0  = $urandom_range(1) == 1;
            v1  = $urandom_range(1) == 1;
            op0 = 2'($urandom_range(3));
            op1 = 2'($urandom_range(3));
            d0  = $urandom;
            d1  = $urandom;
            n0  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            n1  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            cyc();
        end
        rst = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
